neopixel_dma: RTL and testbench
===============================

Name: neopixel_dma

Overview:
- Single-channel read DMA between system SRAM and the NeoPixel colour FIFO.
- Armed by a 0->1 transition of the DMA valid register bit.
- Fetches ceil(num_bytes/4) 32-bit words from src_addr over an OBI manager port (rready in use, one outstanding transaction) and pushes each word into the colour-data FIFO that feeds the NeoPixel timing controller.

Parameters:
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width and FIFO word width; fixed at 32.
- IdWidth, 1, OBI aid/rid width; aid driven to 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- src_addr_i  in  32  DMA source address register
- num_bytes_i  in  32  DMA byte-count register
- valid_i  in  1  bit 0 of DMA valid register
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  AddrWidth  word-aligned read address
- obi_we_o  out  1  constant 0
- obi_be_o  out  4  constant 4'hF
- obi_wdata_o  out  DataWidth  constant 0
- obi_aid_o  out  IdWidth  constant 0
- obi_rvalid_i  in  1  response valid
- obi_rready_o  out  1  response ready
- obi_rdata_i  in  DataWidth  read data
- obi_err_i  in  1  response error
- fifo_wdata_o  out  32  word to colour FIFO
- fifo_push_o  out  1  FIFO push strobe
- fifo_full_i  in  1  FIFO full
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky bus error flag

Behaviour:
- Clocking and reset: already decided — one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: state IDLE; obi_req_o, obi_rready_o, fifo_push_o, busy_o, done_o, err_o = 0; valid edge register = 0; counters = 0.
- Start condition:
  - valid_q registers valid_i; start = valid_i & ~valid_q & state==IDLE.
  - Rising edges seen outside IDLE are ignored; software must drop valid to 0 and raise it again.
- On start:
  - Latch word_addr = src_addr_i & ~3.
  - Latch words_left = (num_bytes_i + 3) >> 2, computed at 33 bits so 32'hFFFF_FFFF yields 2^30.
  - Latch rem = num_bytes_i[1:0].
  - Clear err_o.
  - If words_left == 0, pulse done_o next cycle and stay IDLE. Otherwise go to REQ.
- State REQ:
  - obi_req_o = ~fifo_full_i; obi_addr_o = word_addr.
  - Once obi_req_o is asserted, it and the address are held stable until obi_gnt_i, regardless of fifo_full_i.
  - On req & gnt: go to RESP and increment word_addr by 4 (modulo 2^32, wraps silently).
- State RESP:
  - obi_rready_o = ~fifo_full_i.
  - On rvalid & rready with err=0: fifo_push_o = 1 in the same cycle, fifo_wdata_o = rdata, and words_left decrements.
    - Last word with rem != 0: bytes at index >= rem are zeroed, little-endian (rem=1 keeps [7:0]).
    - If words_left becomes 0: go to IDLE and pulse done_o in the following cycle. Otherwise go to REQ.
  - On rvalid & rready with err=1: no push; err_o = 1; go to IDLE; done_o not asserted.
- Latency: exactly one outstanding request. With gnt in the request cycle and rvalid one cycle later, throughput is one word per 2 cycles.
- busy_o = (state != IDLE).
- Register changes while busy: src_addr_i and num_bytes_i changes have no effect. valid_i falling mid-transfer does not abort.
- Reset mid-operation: returns to IDLE immediately, even with a grant pending. A response arriving after reset is ignored, because rready is 0 in IDLE.
- FIFO full: no request is issued while full. A granted response waits in RESP with rready low; there is no data loss and no push while full.

Test Plan:
- Normal transfer: src=0x1000_0000, num_bytes=12, valid 0->1; memory zero-wait. Expect 3 requests at 0x1000_0000/04/08, 3 pushes with exact data, done_o one pulse, busy_o low afterwards.
- Partial last word: num_bytes=5, word1 = 0xAABBCCDD. Expect 2 pushes, second = 0x0000_00DD.
- Back-pressure: fifo_full_i high after the first push for 10 cycles. Expect obi_req_o held 0 and, for an already granted request, rready 0 with no push. Transfer resumes and completes with correct order.
- Re-arm and ignore: valid held at 1 after completion, num_bytes changed. Expect no new transfer. Toggle 1->0->1: new transfer runs. Edge during busy: ignored.
- Bus error: err_i on the 2nd of 4 responses. Expect 1 push, err_o=1, no done_o, IDLE. The next start clears err_o.
- Misc corners: num_bytes=0 -> done_o pulse, zero requests. src=0xFFFF_FFFC, num_bytes=8 -> addresses 0xFFFF_FFFC then 0x0000_0000. rst_i asserted in RESP -> all outputs 0 next cycle.

Source files
------------

// File: rtl/neopixel_dma.sv
// Single-channel read DMA: fetches ceil(num_bytes/4) words from SRAM over OBI
// and pushes them into the NeoPixel colour FIFO, one outstanding request at a time.
module neopixel_dma #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          num_bytes_i,
  input  logic                 valid_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  output logic [IdWidth-1:0]   obi_aid_o,
  input  logic                 obi_rvalid_i,
  output logic                 obi_rready_o,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i,
  output logic [31:0]          fifo_wdata_o,
  output logic                 fifo_push_o,
  input  logic                 fifo_full_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_valid_q;
  logic                 r_req_pending;
  logic                 r_done;
  logic                 r_err;
  logic [AddrWidth-1:0] r_word_addr;
  logic [30:0]          r_words_left;
  logic [1:0]           r_rem;

  logic                 w_start;
  logic [30:0]          w_words_init;
  logic                 w_req;
  logic                 w_rready;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_last;
  logic [DataWidth-1:0] w_keep_mask;

  // Round-up division without a 33-bit adder: 32'hFFFF_FFFF gives 2^30.
  assign w_words_init = {1'b0, num_bytes_i[31:2]} + 31'(|num_bytes_i[1:0]);
  assign w_start      = valid_i & ~r_valid_q & (r_state == IDLE);
  assign w_last       = (r_words_left == 31'd1);
  assign w_accept     = obi_rvalid_i & w_rready;

  always_comb begin
    w_keep_mask = '1;
    if (w_last) begin
      unique case (r_rem)
        2'd1:    w_keep_mask = 32'h0000_00FF;
        2'd2:    w_keep_mask = 32'h0000_FFFF;
        2'd3:    w_keep_mask = 32'h00FF_FFFF;
        default: w_keep_mask = '1;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_rready     = 1'b0;
    w_push       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start && (w_words_init != '0)) w_state_next = REQ;
      end
      REQ: begin
        // A request already on the bus stays up until granted, even if the FIFO fills.
        w_req = ~fifo_full_i | r_req_pending;
        if (w_req && obi_gnt_i) w_state_next = RESP;
      end
      RESP: begin
        w_rready = ~fifo_full_i;
        if (obi_rvalid_i && w_rready) begin
          if (obi_err_i) begin
            w_state_next = IDLE;
          end else begin
            w_push       = 1'b1;
            w_state_next = w_last ? IDLE : REQ;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_valid_q     <= 1'b0;
      r_req_pending <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_word_addr   <= '0;
      r_words_left  <= '0;
      r_rem         <= '0;
    end else begin
      r_state   <= w_state_next;
      r_valid_q <= valid_i;
      r_done    <= 1'b0;
      if (w_start) begin
        r_word_addr  <= {src_addr_i[AddrWidth-1:2], 2'b00};
        r_words_left <= w_words_init;
        r_rem        <= num_bytes_i[1:0];
        r_err        <= 1'b0;
        r_done       <= (w_words_init == '0);
      end
      if (r_state == REQ) begin
        r_req_pending <= w_req & ~obi_gnt_i;
        if (w_req && obi_gnt_i) r_word_addr <= r_word_addr + AddrWidth'(4);
      end
      if (w_accept) begin
        if (obi_err_i) begin
          r_err <= 1'b1;
        end else begin
          r_words_left <= r_words_left - 31'd1;
          r_done       <= w_last;
        end
      end
    end
  end

  assign obi_req_o    = w_req;
  assign obi_addr_o   = r_word_addr;
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = 4'hF;
  assign obi_wdata_o  = '0;
  assign obi_aid_o    = '0;
  assign obi_rready_o = w_rready;
  assign fifo_wdata_o = obi_rdata_i & w_keep_mask;
  assign fifo_push_o  = w_push;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_neopixel_dma.sv
// Self-checking bench for neopixel_dma: randomized OBI memory responder plus a
// transfer-level reference model of addresses, pushed words and completion flags.
module tb_neopixel_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src_addr = '0;
  logic [31:0] num_bytes = '0;
  logic        valid = 1'b0;
  logic        obi_req_o;
  logic        obi_gnt = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic [0:0]  obi_aid_o;
  logic        obi_rvalid = 1'b0;
  logic        obi_rready_o;
  logic [31:0] obi_rdata = '0;
  logic        obi_err = 1'b0;
  logic [31:0] fifo_wdata_o;
  logic        fifo_push_o;
  logic        fifo_full = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  neopixel_dma dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .src_addr_i   (src_addr),
    .num_bytes_i  (num_bytes),
    .valid_i      (valid),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_aid_o    (obi_aid_o),
    .obi_rvalid_i (obi_rvalid),
    .obi_rready_o (obi_rready_o),
    .obi_rdata_i  (obi_rdata),
    .obi_err_i    (obi_err),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_push_o  (fifo_push_o),
    .fifo_full_i  (fifo_full),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] seen_addr [$];
  logic [31:0] push_data [$];
  int          done_cnt  = 0;
  int          busy_cnt  = 0;
  int          resp_idx  = 0;

  bit          gnt_always = 1'b1;
  int          lat_min    = 0;
  int          lat_max    = 0;
  int          err_idx    = -1;
  bit          full_rand  = 1'b0;
  bit          stale      = 1'b0;
  bit          resp_pending = 1'b0;
  int          resp_delay = 0;
  logic [31:0] resp_addr  = '0;
  bit          prev_hold  = 1'b0;
  logic [31:0] prev_addr  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_mem(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Memory responder: drive inputs on the falling edge, then observe the settled cycle.
  always @(negedge clk) begin
    if (full_rand) fifo_full = ($urandom_range(0, 3) == 0);
    if (resp_pending && resp_delay == 0) begin
      obi_rvalid = 1'b1;
      obi_rdata  = get_mem(resp_addr);
      obi_err    = (resp_idx == err_idx);
    end else begin
      obi_rvalid = 1'b0;
      obi_rdata  = $urandom;
      obi_err    = 1'b0;
    end
    obi_gnt = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
    #1;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      check("push_rule", fifo_push_o, obi_rvalid && obi_rready_o && !obi_err);
      if (fifo_full) begin
        check("rready_full", obi_rready_o, 1'b0);
        if (!prev_hold) check("req_full", obi_req_o, 1'b0);
      end
      if (prev_hold) begin
        check("req_held", obi_req_o, 1'b1);
        check("addr_held", obi_addr_o, prev_addr);
      end
      if (resp_pending && !fifo_full && !stale) check("rready_open", obi_rready_o, 1'b1);

      if (obi_rvalid && obi_rready_o) begin
        resp_pending = 1'b0;
        resp_idx++;
      end else if (resp_pending && resp_delay > 0) begin
        resp_delay--;
      end
      if (obi_req_o && obi_gnt) begin
        seen_addr.push_back(obi_addr_o);
        resp_pending = 1'b1;
        resp_addr    = obi_addr_o;
        resp_delay   = $urandom_range(lat_min, lat_max);
      end
      if (fifo_push_o) push_data.push_back(fifo_wdata_o);
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
      prev_hold = obi_req_o && !obi_gnt;
      prev_addr = obi_addr_o;
    end
  end

  task automatic clear_sb();
    seen_addr.delete();
    push_data.delete();
    done_cnt = 0;
    busy_cnt = 0;
    resp_idx = 0;
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] nb);
    @(negedge clk);
    src_addr  = src;
    num_bytes = nb;
    valid     = 1'b0;
    @(negedge clk);
    valid = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (i >= 1 && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle_in_time"}, ok, 1'b1);
  endtask

  // Reference: word i is fetched from (src & ~3) + 4*i; the tail word keeps nb%4 low bytes.
  task automatic check_xfer(input string tag, input logic [31:0] src, input logic [31:0] nb,
                            input int eidx);
    longint      n_words;
    int          n_resp;
    int          n_push;
    int          r;
    logic [31:0] a;
    logic [31:0] d;
    n_words = (longint'(nb) + 3) / 4;
    n_resp  = (eidx >= 0) ? eidx + 1 : int'(n_words);
    n_push  = (eidx >= 0) ? eidx : int'(n_words);
    r       = int'(nb % 32'd4);
    check({tag, "_nreq"}, seen_addr.size(), n_resp);
    check({tag, "_npush"}, push_data.size(), n_push);
    for (int i = 0; i < n_resp && i < seen_addr.size(); i++) begin
      a = (src & 32'hFFFF_FFFC) + 32'(4 * i);
      check($sformatf("%s_addr%0d", tag, i), seen_addr[i], a);
    end
    for (int i = 0; i < n_push && i < push_data.size(); i++) begin
      a = (src & 32'hFFFF_FFFC) + 32'(4 * i);
      d = get_mem(a);
      if (longint'(i) == n_words - 1 && r != 0) d = d & ((32'd1 << (8 * r)) - 32'd1);
      check($sformatf("%s_data%0d", tag, i), push_data[i], d);
    end
    check({tag, "_done"}, done_cnt, (eidx >= 0) ? 0 : 1);
    check({tag, "_err"}, err_o, (eidx >= 0) ? 1'b1 : 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    bit          ok;
    int          n0;
    logic [31:0] s;
    logic [31:0] n;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_req", obi_req_o, 1'b0);
    check("rst_rready", obi_rready_o, 1'b0);
    check("rst_push", fifo_push_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("const_we", obi_we_o, 1'b0);
    check("const_be", obi_be_o, 4'hF);
    check("const_wdata", obi_wdata_o, 32'h0);
    check("const_aid", obi_aid_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Normal zero-wait transfer: one word per two busy cycles
    clear_sb();
    start_xfer(32'h1000_0000, 32'd12);
    wait_idle("normal", 100);
    check_xfer("normal", 32'h1000_0000, 32'd12, -1);
    check("normal_busy_cycles", busy_cnt, 6);

    // Valid held high after completion: no re-trigger
    clear_sb();
    @(negedge clk);
    num_bytes = 32'd40;
    repeat (10) @(negedge clk);
    #2;
    check("hold_nreq", seen_addr.size(), 0);
    check("hold_done", done_cnt, 0);
    check("hold_busy", busy_o, 1'b0);

    // Partial last word
    clear_sb();
    mem[32'h2000_0004] = 32'hAABB_CCDD;
    start_xfer(32'h2000_0002, 32'd5);
    wait_idle("partial", 100);
    check_xfer("partial", 32'h2000_0002, 32'd5, -1);
    if (push_data.size() == 2) check("partial_tail", push_data[1], 32'h0000_00DD);

    // Toggled valid starts a new transfer; an edge while busy is ignored
    gnt_always = 1'b0;
    lat_max    = 2;
    clear_sb();
    start_xfer(32'h1000_0100, 32'd16);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    wait_idle("rearm", 300);
    check_xfer("rearm", 32'h1000_0100, 32'd16, -1);
    repeat (10) @(negedge clk);
    #2;
    check("rearm_no_retrigger", seen_addr.size(), 4);

    // Back-pressure: FIFO full for 10 cycles after the first push
    clear_sb();
    start_xfer(32'h3000_0000, 32'd32);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (push_data.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_first_push", ok, 1'b1);
    n0 = push_data.size();
    @(negedge clk);
    fifo_full = 1'b1;
    repeat (9) @(negedge clk);
    #2;
    check("bp_no_push_while_full", push_data.size(), n0);
    @(negedge clk);
    fifo_full = 1'b0;
    wait_idle("bp", 300);
    check_xfer("bp", 32'h3000_0000, 32'd32, -1);

    // Bus error on the second response, then a fresh start clears err_o
    clear_sb();
    err_idx = 1;
    start_xfer(32'h5000_0010, 32'd16);
    wait_idle("buserr", 300);
    check_xfer("buserr", 32'h5000_0010, 32'd16, 1);
    err_idx = -1;
    clear_sb();
    start_xfer(32'h5000_0100, 32'd8);
    @(negedge clk);
    #2;
    check("err_cleared_on_start", err_o, 1'b0);
    wait_idle("after_err", 300);
    check_xfer("after_err", 32'h5000_0100, 32'd8, -1);

    // Zero-length transfer
    clear_sb();
    start_xfer(32'h6000_0000, 32'd0);
    wait_idle("zero", 20);
    check_xfer("zero", 32'h6000_0000, 32'd0, -1);

    // Address wrap
    clear_sb();
    start_xfer(32'hFFFF_FFFC, 32'd8);
    wait_idle("wrap", 300);
    check_xfer("wrap", 32'hFFFF_FFFC, 32'd8, -1);
    if (seen_addr.size() == 2) check("wrap_second_addr", seen_addr[1], 32'h0000_0000);

    // Reset while a granted response is outstanding
    clear_sb();
    gnt_always = 1'b1;
    lat_min    = 3;
    lat_max    = 3;
    start_xfer(32'h4000_0000, 32'd16);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (seen_addr.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("mrst_granted", ok, 1'b1);
    @(negedge clk);
    #2;
    check("mrst_busy_before", busy_o, 1'b1);
    rst   = 1'b1;
    valid = 1'b0;
    stale = 1'b1;
    @(negedge clk);
    #2;
    check("mrst_req", obi_req_o, 1'b0);
    check("mrst_rready", obi_rready_o, 1'b0);
    check("mrst_push", fifo_push_o, 1'b0);
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_done", done_o, 1'b0);
    check("mrst_err", err_o, 1'b0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check("mrst_late_resp_ignored", push_data.size(), 0);
    check("mrst_stays_idle", busy_o, 1'b0);
    @(negedge clk);
    #3;
    resp_pending = 1'b0;
    stale        = 1'b0;
    lat_min      = 0;
    lat_max      = 2;
    gnt_always   = 1'b0;

    // Randomized transfers with random FIFO back-pressure
    full_rand = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = $urandom;
      n = 32'($urandom_range(0, 40));
      clear_sb();
      start_xfer(s, n);
      wait_idle($sformatf("rnd%0d", k), 2000);
      check_xfer($sformatf("rnd%0d", k), s, n, -1);
    end
    @(negedge clk);
    full_rand = 1'b0;
    fifo_full = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
